rv32i_load_store_unit: RTL and testbench

// Sits between the multicycle core's data-memory port and the word-wide (32b, word-addressed) memory.

---
 rtl/rv32i_load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_rv32i_load_store_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_load_store_unit.sv
// Load/store unit between the core's data port and a word-addressed memory.
// Sub-word loads are lane-extracted and extended; sub-word stores use read-modify-write.
module rv32i_load_store_unit #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wr_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_rd_data,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRdWait  = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StMerge   = 3'd3;
  localparam logic [2:0] StWrite   = 3'd4;
  localparam logic [2:0] StResp    = 3'd5;

  localparam logic [1:0] LatInit = 2'(RD_LATENCY - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rsp_rd_data_q, rsp_rd_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic        req_err;

  function automatic logic [31:0] load_ext(input logic [31:0] data, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{off, 3'b000} +: 8];
    h = off[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] data, input logic [15:0] wd,
                                              input logic is_half, input logic [1:0] off);
    logic [31:0] r;
    r = data;
    if (is_half) r[{off[1], 4'b0000} +: 16] = wd;
    else         r[{off, 3'b000} +: 8] = wd[7:0];
    return r;
  endfunction

  always_comb begin
    case (req_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = (req_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    if (req_write && req_funct3[2]) req_err = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    off_d         = off_q;
    funct3_d      = funct3_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    rsp_rd_data_d = rsp_rd_data_q;
    rsp_err_d     = rsp_err_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          off_d    = req_addr[1:0];
          funct3_d = req_funct3;
          write_d  = req_write;
          wdata_d  = req_wr_data[15:0];
          if (req_err) begin
            rsp_err_d     = 1'b1;
            rsp_rd_data_d = 32'h0;
            state_d       = StResp;
          end else begin
            rsp_err_d  = 1'b0;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_write && req_funct3[1]) begin
              mem_wr_data_d = req_wr_data;
              state_d       = StWrite;
            end else begin
              cnt_d   = LatInit;
              state_d = StRdWait;
            end
          end
        end
      end
      StRdWait: begin
        if (cnt_q == 2'd0) state_d = write_q ? StMerge : StCapture;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StCapture: begin
        rsp_rd_data_d = load_ext(mem_rd_data, funct3_q, off_q);
        state_d       = StResp;
      end
      StMerge: begin
        mem_wr_data_d = store_merge(mem_rd_data, wdata_q, funct3_q[0], off_q);
        state_d       = StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 2'd0;
      off_q         <= 2'd0;
      funct3_q      <= 3'd0;
      write_q       <= 1'b0;
      wdata_q       <= 16'h0;
      rsp_rd_data_q <= 32'h0;
      rsp_err_q     <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wr_data_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      off_q         <= off_d;
      funct3_q      <= funct3_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      rsp_err_q     <= rsp_err_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_rd_data = rsp_rd_data_q;
  assign rsp_err     = rsp_err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  // Combinational gate so a write can never land in a reset cycle.
  assign mem_wr_ena  = (state_q == StWrite) && !rst;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Bench for rv32i_load_store_unit: directed vector table on an L=1 instance,
// plus hand sequences for L=3 busy behaviour and reset during a merge.
module tb_rv32i_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        v1, w1, rdy1, rv1, er1, mwe1;
  logic [2:0]  f1;
  logic [31:0] a1, d1, rd1, ma1, mwd1, mrd1;
  logic        v3, w3, rdy3, rv3, er3, mwe3;
  logic [2:0]  f3;
  logic [31:0] a3, d3, rd3, ma3, mwd3, mrd3;

  rv32i_load_store_unit #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_funct3(f1), .req_addr(a1), .req_wr_data(d1), .rsp_valid(rv1),
    .rsp_rd_data(rd1), .rsp_err(er1), .mem_addr(ma1), .mem_wr_data(mwd1),
    .mem_wr_ena(mwe1), .mem_rd_data(mrd1)
  );

  rv32i_load_store_unit #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_write(w3),
    .req_funct3(f3), .req_addr(a3), .req_wr_data(d3), .rsp_valid(rv3),
    .rsp_rd_data(rd3), .rsp_err(er3), .mem_addr(ma3), .mem_wr_data(mwd3),
    .mem_wr_ena(mwe3), .mem_rd_data(mrd3)
  );

  // Memory models: read data appears L cycles after the address.
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_dat;
  logic [31:0] ra1_q;
  logic [31:0] ra3_q [0:2];

  always @(posedge clk) begin
    ra1_q    <= ma1;
    ra3_q[0] <= ma3;
    ra3_q[1] <= ra3_q[0];
    ra3_q[2] <= ra3_q[1];
    if (pl_en) begin
      mem1[pl_idx] <= pl_dat;
      mem3[pl_idx] <= pl_dat;
    end else begin
      if (mwe1) mem1[ma1[11:2]] <= mwd1;
      if (mwe3) mem3[ma3[11:2]] <= mwd3;
    end
  end

  assign mrd1 = mem1[ra1_q[11:2]];
  assign mrd3 = mem3[ra3_q[2][11:2]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] dat);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = addr[11:2];
    pl_dat = dat;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          rsp_cyc;
    int          wr_cyc;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    logic [31:0] mem;
  } vec_t;

  vec_t vecs [18];

  task automatic run1(input vec_t v, input int idx);
    int rsp_c, wr_c, nrsp, nwr;
    logic e;
    logic [31:0] r;
    rsp_c = -1; wr_c = 0; nrsp = 0; nwr = 0; e = 1'b0; r = 32'h0;
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), rdy1, 1'b1);
    v1 = 1'b1; w1 = v.w; f1 = v.f3; a1 = v.addr; d1 = v.wd;
    @(negedge clk);
    v1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mwe1) begin nwr++; wr_c = c; end
      if (rv1) begin nrsp++; rsp_c = c; e = er1; r = rd1; end
      @(negedge clk);
    end
    chk($sformatf("v%0d rsp_cycle", idx), rsp_c, v.rsp_cyc);
    chk($sformatf("v%0d rsp_count", idx), nrsp, 1);
    chk($sformatf("v%0d wr_count", idx), nwr, (v.wr_cyc != 0) ? 1 : 0);
    chk($sformatf("v%0d wr_cycle", idx), wr_c, v.wr_cyc);
    chk($sformatf("v%0d err", idx), e, v.err);
    if (v.chk_rd) chk($sformatf("v%0d rd_data", idx), r, v.rd);
    chk($sformatf("v%0d mem_word", idx), mem1[v.addr[11:2]], v.mem);
  endtask

  initial begin
    int nrsp, nwr, rsp_c;
    logic [31:0] r;

    //          w     f3      addr           wdata          rsp wr err  chk  rd             mem
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,         3, 0, 1'b0, 1'b1, 32'hFFFFFFAA, 32'h8899AABB};
    vecs[1]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,         3, 0, 1'b0, 1'b1, 32'h00000088, 32'h8899AABB};
    vecs[2]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         3, 0, 1'b0, 1'b1, 32'hFFFF8899, 32'h8899AABB};
    vecs[3]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         3, 0, 1'b0, 1'b1, 32'h8899AABB, 32'h8899AABB};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,         3, 0, 1'b0, 1'b1, 32'h0000AABB, 32'h8899AABB};
    vecs[5]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,         3, 0, 1'b0, 1'b1, 32'hFFFFFFBB, 32'h8899AABB};
    vecs[6]  = '{1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0,         3, 0, 1'b0, 1'b1, 32'h0000007F, 32'h7F000000};
    vecs[7]  = '{1'b1, 3'b000, 32'h0000_0202, 32'hDEADBEEF,  4, 3, 1'b0, 1'b0, 32'h0,        32'h11EF3344};
    vecs[8]  = '{1'b1, 3'b001, 32'h0000_0200, 32'h0000CAFE,  4, 3, 1'b0, 1'b0, 32'h0,        32'h11EFCAFE};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_0300, 32'hA5A5A5A5,  2, 1, 1'b0, 1'b0, 32'h0,        32'hA5A5A5A5};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_0302, 32'h0,         1, 0, 1'b1, 1'b1, 32'h0,        32'hA5A5A5A5};
    vecs[11] = '{1'b1, 3'b001, 32'h0000_0201, 32'h00001234,  1, 0, 1'b1, 1'b1, 32'h0,        32'h11EFCAFE};
    vecs[12] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         1, 0, 1'b1, 1'b1, 32'h0,        32'h8899AABB};
    vecs[13] = '{1'b1, 3'b100, 32'h0000_0200, 32'h000000FF,  1, 0, 1'b1, 1'b1, 32'h0,        32'h11EFCAFE};
    vecs[14] = '{1'b0, 3'b001, 32'h0000_0200, 32'h0,         3, 0, 1'b0, 1'b1, 32'hFFFFCAFE, 32'h11EFCAFE};
    vecs[15] = '{1'b0, 3'b101, 32'h0000_0202, 32'h0,         3, 0, 1'b0, 1'b1, 32'h000011EF, 32'h11EFCAFE};
    vecs[16] = '{1'b1, 3'b000, 32'hFFFF_FFFC, 32'h123456AA,  4, 3, 1'b0, 1'b0, 32'h0,        32'h7F0000AA};
    vecs[17] = '{1'b0, 3'b101, 32'h0000_0103, 32'h0,         1, 0, 1'b1, 1'b1, 32'h0,        32'h8899AABB};

    rst = 1'b1; pl_en = 1'b0; pl_idx = 10'h0; pl_dat = 32'h0;
    v1 = 1'b0; w1 = 1'b0; f1 = 3'b0; a1 = 32'h0; d1 = 32'h0;
    v3 = 1'b0; w3 = 1'b0; f3 = 3'b0; a3 = 32'h0; d3 = 32'h0;
    preload(32'h0000_0000, 32'h0);
    preload(32'h0000_0100, 32'h8899AABB);
    preload(32'h0000_0200, 32'h11223344);
    preload(32'h0000_0300, 32'h0);
    preload(32'h0000_0FFC, 32'h7F000000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready", rdy1, 1'b1);
    chk("reset rsp_valid", rv1, 1'b0);
    chk("reset rsp_err", er1, 1'b0);
    chk("reset rsp_rd_data", rd1, 32'h0);
    chk("reset mem_addr", ma1, 32'h0);
    chk("reset mem_wr_data", mwd1, 32'h0);
    chk("reset mem_wr_ena", mwe1, 1'b0);
    chk("reset l3 req_ready", rdy3, 1'b1);

    for (int i = 0; i < 18; i++) run1(vecs[i], i);

    // L=3 word load with req_valid held through the busy window.
    nrsp = 0; rsp_c = -1; r = 32'h0;
    @(negedge clk);
    v3 = 1'b1; w3 = 1'b0; f3 = 3'b010; a3 = 32'h0000_0100; d3 = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 5) chk($sformatf("l3 ready_low T+%0d", c), rdy3, 1'b0);
      if (c == 6) chk("l3 ready_back", rdy3, 1'b1);
      if (rv3) begin nrsp++; rsp_c = c; r = rd3; end
      if (c == 5) v3 = 1'b0;
    end
    chk("l3 rsp_cycle", rsp_c, 5);
    chk("l3 rsp_count", nrsp, 1);
    chk("l3 rd_data", r, 32'h8899AABB);

    // Reset asserted while an sb is in MERGE: nothing may be written.
    run1(vecs[0], 100);
    nwr = 0; nrsp = 0;
    @(negedge clk);
    v1 = 1'b1; w1 = 1'b1; f1 = 3'b000; a1 = 32'h0000_0201; d1 = 32'h00000055;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) v1 = 1'b0;
      if (mwe1) nwr++;
      if (rv1) nrsp++;
      if (c == 4) begin
        chk("rstmid req_ready", rdy1, 1'b1);
        chk("rstmid rsp_valid", rv1, 1'b0);
        chk("rstmid rsp_err", er1, 1'b0);
        chk("rstmid rsp_rd_data", rd1, 32'h0);
        chk("rstmid mem_addr", ma1, 32'h0);
        chk("rstmid mem_wr_data", mwd1, 32'h0);
        chk("rstmid mem_wr_ena", mwe1, 1'b0);
      end
      if (c == 2) rst = 1'b1;
      if (c == 3) rst = 1'b0;
    end
    chk("rstmid wr_count", nwr, 0);
    chk("rstmid rsp_count", nrsp, 0);
    chk("rstmid mem_word", mem1[10'h080], 32'h11EFCAFE);

    run1(vecs[14], 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
